// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage
//   Execute stage of the 5-stage scalar pipeline. It latches the instruction
//   offered by decode, computes the ALU result, and issues a single load/store
//   request per memory instruction to the data SRAM using a req/addr_ok
//   handshake. It then hands the instruction to the memory stage, and returns
//   load-use and forwarding information to decode.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   ms_allowin          memory stage can accept an instruction
//   ds_to_es_valid/bus  instruction offered by decode (151-bit bus)
//   es_allowin          execute can accept from decode
//   es_to_ms_valid/bus  instruction offered to memory stage (71-bit bus)
//   es_valid            execute holds a valid instruction
//   es_to_ds_bus        {load in execute, es_to_ds_dest} for load-use stall
//   es_to_ds_dest       destination register if it will be written, else 0
//   es_forward_data     ALU result forwarded to decode
//   data_sram_*         request side of the data SRAM interface
// -----------------------------------------------------------------------------
module exe_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         ms_allowin,
  input  logic         ds_to_es_valid,
  input  logic [150:0] ds_to_es_bus,
  output logic         es_allowin,
  output logic         es_to_ms_valid,
  output logic [70:0]  es_to_ms_bus,
  output logic         es_valid,
  output logic [5:0]   es_to_ds_bus,
  output logic [4:0]   es_to_ds_dest,
  output logic [31:0]  es_forward_data,
  output logic         data_sram_req,
  output logic         data_sram_wr,
  output logic [1:0]   data_sram_size,
  output logic [3:0]   data_sram_wstrb,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  input  logic         data_sram_addr_ok
);

  // Field layout of the decode-to-execute bus, MSB first.
  typedef struct packed {
    logic [31:0] pc;
    logic [11:0] alu_op;
    logic        src2_is_4;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [31:0] rj_value;
    logic [31:0] rkd_value;
    logic        res_from_mem;
  } ds_bus_t;

  ds_bus_t     bus_q, bus_d;
  logic        es_valid_q, es_valid_d;
  logic        req_done_q, req_done_d;

  logic        mem_op;
  logic        addr_hs;
  logic        es_ready_go;
  logic [31:0] src1, src2;
  logic [4:0]  shamt;
  logic [31:0] alu_result;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  assign src1  = bus_q.src1_is_pc ? bus_q.pc : bus_q.rj_value;
  assign src2  = (bus_q.src2_is_imm | bus_q.src2_is_4) ? bus_q.imm : bus_q.rkd_value;
  assign shamt = src2[4:0];

  // alu_op is one-hot: OR-ing the gated results gives the selected result,
  // and an all-zero alu_op naturally yields 0.
  always_comb begin
    // NOTE: default assignment first so no path through this block can infer a latch.
    alu_result = '0;
    if (bus_q.alu_op[0])  alu_result |= src1 + src2;
    if (bus_q.alu_op[1])  alu_result |= src1 - src2;
    if (bus_q.alu_op[2])  alu_result |= {31'b0, $signed(src1) < $signed(src2)};
    if (bus_q.alu_op[3])  alu_result |= {31'b0, src1 < src2};
    if (bus_q.alu_op[4])  alu_result |= src1 & src2;
    if (bus_q.alu_op[5])  alu_result |= ~(src1 | src2);
    if (bus_q.alu_op[6])  alu_result |= src1 | src2;
    if (bus_q.alu_op[7])  alu_result |= src1 ^ src2;
    if (bus_q.alu_op[8])  alu_result |= src1 << shamt;
    if (bus_q.alu_op[9])  alu_result |= src1 >> shamt;
    if (bus_q.alu_op[10]) alu_result |= $unsigned($signed(src1) >>> shamt);
    if (bus_q.alu_op[11]) alu_result |= src2;
  end

  // ---------------------------------------------------------------------------
  // Memory request and pipeline handshake
  // ---------------------------------------------------------------------------
  assign mem_op        = bus_q.res_from_mem | bus_q.mem_we;
  // req_done guarantees one request per instruction even when the memory
  // stage stalls after the address was accepted.
  assign data_sram_req = es_valid_q & mem_op & ~req_done_q;
  assign addr_hs       = data_sram_req & data_sram_addr_ok;
  assign es_ready_go   = ~mem_op | req_done_q | addr_hs;
  assign es_allowin    = ~es_valid_q | (es_ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid_q & es_ready_go;

  always_comb begin
    es_valid_d = es_allowin ? ds_to_es_valid : es_valid_q;
    bus_d      = (ds_to_es_valid & es_allowin) ? ds_bus_t'(ds_to_es_bus) : bus_q;
    req_done_d = req_done_q;
    // Leaving or replacement wins over a same-cycle accept, so the flag never
    // leaks into the next instruction.
    if ((es_to_ms_valid & ms_allowin) | (ds_to_es_valid & es_allowin))
      req_done_d = 1'b0;
    else if (addr_hs)
      req_done_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the bus register is reset too, so every output is defined
    // (and zero) straight out of reset rather than only qualified by es_valid.
    if (reset) begin
      es_valid_q <= 1'b0;
      req_done_q <= 1'b0;
      bus_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      es_valid_q <= es_valid_d;
      req_done_q <= req_done_d;
      bus_q      <= bus_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign es_valid        = es_valid_q;
  assign es_to_ms_bus    = {bus_q.pc, bus_q.res_from_mem, bus_q.gr_we, bus_q.dest, alu_result};
  assign es_to_ds_dest   = (es_valid_q & bus_q.gr_we) ? bus_q.dest : 5'd0;
  assign es_to_ds_bus    = {es_valid_q & bus_q.res_from_mem, es_to_ds_dest};
  assign es_forward_data = alu_result;

  assign data_sram_wr    = bus_q.mem_we;
  assign data_sram_size  = 2'b10;
  assign data_sram_wstrb = bus_q.mem_we ? 4'hf : 4'h0;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = bus_q.rkd_value;

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

  logic         clk;
  logic         reset;
  logic         ms_allowin;
  logic         ds_to_es_valid;
  logic [150:0] ds_to_es_bus;
  logic         es_allowin;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic         es_valid;
  logic [5:0]   es_to_ds_bus;
  logic [4:0]   es_to_ds_dest;
  logic [31:0]  es_forward_data;
  logic         data_sram_req;
  logic         data_sram_wr;
  logic [1:0]   data_sram_size;
  logic [3:0]   data_sram_wstrb;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         data_sram_addr_ok;

  int errors = 0;
  int checks = 0;
  int accept_cnt = 0;

  localparam logic [11:0] OP_ADD  = 12'h001;
  localparam logic [11:0] OP_SUB  = 12'h002;
  localparam logic [11:0] OP_SLT  = 12'h004;
  localparam logic [11:0] OP_SLTU = 12'h008;
  localparam logic [11:0] OP_AND  = 12'h010;
  localparam logic [11:0] OP_NOR  = 12'h020;
  localparam logic [11:0] OP_OR   = 12'h040;
  localparam logic [11:0] OP_XOR  = 12'h080;
  localparam logic [11:0] OP_SLL  = 12'h100;
  localparam logic [11:0] OP_SRL  = 12'h200;
  localparam logic [11:0] OP_SRA  = 12'h400;
  localparam logic [11:0] OP_LUI  = 12'h800;

  exe_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_allowin        (ms_allowin),
    .ds_to_es_valid    (ds_to_es_valid),
    .ds_to_es_bus      (ds_to_es_bus),
    .es_allowin        (es_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .es_valid          (es_valid),
    .es_to_ds_bus      (es_to_ds_bus),
    .es_to_ds_dest     (es_to_ds_dest),
    .es_forward_data   (es_forward_data),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts accepted SRAM requests; inputs change 1 time unit after the edge.
  always @(posedge clk)
    if (data_sram_req && data_sram_addr_ok) accept_cnt <= accept_cnt + 1;

  function automatic logic [150:0] make_bus(
    input logic [31:0] pc, input logic [11:0] alu_op,
    input logic src2_is_4, input logic src1_is_pc, input logic src2_is_imm,
    input logic gr_we, input logic mem_we, input logic [4:0] dest,
    input logic [31:0] imm, input logic [31:0] rj, input logic [31:0] rkd,
    input logic res_from_mem);
    return {pc, alu_op, src2_is_4, src1_is_pc, src2_is_imm, gr_we, mem_we,
            dest, imm, rj, rkd, res_from_mem};
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction for one edge; assumes es_allowin is high.
  task automatic issue(input logic [150:0] bus);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = bus;
    tick();
    ds_to_es_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (es_valid !== 1'b0 || es_to_ms_valid !== 1'b0 || es_allowin !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: es_valid=%b es_to_ms_valid=%b es_allowin=%b, required 0 0 1",
               es_valid, es_to_ms_valid, es_allowin);
    end
    checks++;
    if (es_to_ms_bus !== 71'd0 || es_to_ds_bus !== 6'd0 || es_forward_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus: ms_bus=%h ds_bus=%h fwd=%h, required all 0",
               es_to_ms_bus, es_to_ds_bus, es_forward_data);
    end
    checks++;
    if (data_sram_req !== 1'b0 || data_sram_wr !== 1'b0 || data_sram_size !== 2'b10 ||
        data_sram_wstrb !== 4'h0 || data_sram_addr !== 32'd0 || data_sram_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_sram: req=%b wr=%b size=%b wstrb=%h addr=%h wdata=%h, required 0 0 10 0 0 0",
               data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_handshake();
    ms_allowin = 1'b1;
    issue(make_bus(32'h1C000010, OP_ADD, 0, 0, 0, 1, 0, 5'd3, 32'd0, 32'd5, 32'd7, 0));
    checks++;
    if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[31:0] !== 32'd12 || es_forward_data !== 32'd12) begin
      errors++;
      $display("FAIL handshake_result: valid=%b result=%h fwd=%h, required 1 0000000c 0000000c",
               es_to_ms_valid, es_to_ms_bus[31:0], es_forward_data);
    end
    checks++;
    if (es_to_ds_dest !== 5'd3 || es_to_ds_bus !== 6'h03 || data_sram_req !== 1'b0 ||
        es_to_ms_bus[70:32] !== {32'h1C000010, 1'b0, 1'b1, 5'd3}) begin
      errors++;
      $display("FAIL handshake_fields: dest=%0d ds_bus=%h req=%b ms_hi=%h, required 3 03 0 %h",
               es_to_ds_dest, es_to_ds_bus, data_sram_req, es_to_ms_bus[70:32],
               {32'h1C000010, 1'b0, 1'b1, 5'd3});
    end
    tick();
    checks++;
    if (es_valid !== 1'b0 || es_to_ds_dest !== 5'd0) begin
      errors++;
      $display("FAIL handshake_drain: es_valid=%b dest=%0d, required 0 0", es_valid, es_to_ds_dest);
    end
  endtask

  task automatic test_alu();
    logic [11:0] ops  [12] = '{OP_SLT, OP_SLTU, OP_SRA, OP_SUB, OP_NOR, OP_SRL,
                               OP_SLL, OP_XOR, OP_OR, OP_AND, 12'h000, OP_ADD};
    logic [31:0] a    [12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd5, 32'd0,
                               32'h80000000, 32'd1, 32'hF0F0F0F0, 32'h0000FF00,
                               32'h0000FF00, 32'h12345678, 32'hFFFFFFFF};
    logic [31:0] b    [12] = '{32'd1, 32'd1, 32'd4, 32'd7, 32'd0, 32'd4, 32'h21,
                               32'hFF00FF00, 32'h00FF0000, 32'h00FFFF00, 32'h9ABCDEF0, 32'd2};
    logic [31:0] expv [12] = '{32'd1, 32'd0, 32'hF8000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                               32'h08000000, 32'd2, 32'h0FF00FF0, 32'h00FFFF00,
                               32'h0000FF00, 32'd0, 32'd1};
    ms_allowin = 1'b1;
    for (int i = 0; i < 12; i++) begin
      issue(make_bus(32'h1C000100, ops[i], 0, 0, 0, 1, 0, 5'd4, 32'd0, a[i], b[i], 0));
      checks++;
      if (es_forward_data !== expv[i] || es_to_ms_bus[31:0] !== expv[i]) begin
        errors++;
        $display("FAIL alu_vec%0d op=%h: fwd=%h ms=%h, required %h",
                 i, ops[i], es_forward_data, es_to_ms_bus[31:0], expv[i]);
      end
    end
    // lu12i: immediate passes through
    issue(make_bus(32'h1C000200, OP_LUI, 0, 0, 1, 1, 0, 5'd6, 32'h12345000, 32'hAAAAAAAA, 32'h55555555, 0));
    checks++;
    if (es_forward_data !== 32'h12345000) begin
      errors++;
      $display("FAIL alu_lu12i: got %h, required 12345000", es_forward_data);
    end
    // bl: pc + 4 via src1_is_pc and src2_is_4 (decode supplies imm=4)
    issue(make_bus(32'h1C000000, OP_ADD, 1, 1, 0, 1, 0, 5'd1, 32'd4, 32'h11111111, 32'h22222222, 0));
    checks++;
    if (es_forward_data !== 32'h1C000004) begin
      errors++;
      $display("FAIL alu_bl: got %h, required 1c000004", es_forward_data);
    end
    tick();
  endtask

  task automatic test_store();
    int base;
    ms_allowin        = 1'b1;
    data_sram_addr_ok = 1'b0;
    base = accept_cnt;
    // st.w: addr = rj + imm = 0x100, gr_we=0 with a nonzero dest field
    issue(make_bus(32'h1C000300, OP_ADD, 0, 0, 1, 0, 1, 5'd7, 32'h0, 32'h100, 32'hDEADBEEF, 0));
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h100 || data_sram_wstrb !== 4'hf ||
          data_sram_wr !== 1'b1 || data_sram_wdata !== 32'hDEADBEEF || es_to_ms_valid !== 1'b0 ||
          es_allowin !== 1'b0 || es_to_ds_dest !== 5'd0) begin
        errors++;
        $display("FAIL store_wait%0d: req=%b addr=%h wstrb=%h wr=%b wdata=%h ms_v=%b allowin=%b dest=%0d, required 1 100 f 1 deadbeef 0 0 0",
                 c, data_sram_req, data_sram_addr, data_sram_wstrb, data_sram_wr,
                 data_sram_wdata, es_to_ms_valid, es_allowin, es_to_ds_dest);
      end
      tick();
    end
    data_sram_addr_ok = 1'b1;
    #1;
    checks++;
    if (es_to_ms_valid !== 1'b1 || es_allowin !== 1'b1) begin
      errors++;
      $display("FAIL store_accept: ms_v=%b allowin=%b, required 1 1", es_to_ms_valid, es_allowin);
    end
    tick();
    data_sram_addr_ok = 1'b0;
    #1;
    checks++;
    if (data_sram_req !== 1'b0 || es_valid !== 1'b0 || accept_cnt - base !== 1) begin
      errors++;
      $display("FAIL store_done: req=%b es_valid=%b accepts=%0d, required 0 0 1",
               data_sram_req, es_valid, accept_cnt - base);
    end
  endtask

  task automatic test_backpressure();
    int base;
    ms_allowin        = 1'b0;
    data_sram_addr_ok = 1'b1;
    base = accept_cnt;
    // ld.w: addr = 0x200 + 8, dest 9
    issue(make_bus(32'h1C000400, OP_ADD, 0, 0, 1, 1, 0, 5'd9, 32'd8, 32'h200, 32'h0, 1));
    checks++;
    if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h208 || data_sram_wr !== 1'b0 ||
        data_sram_wstrb !== 4'h0) begin
      errors++;
      $display("FAIL load_req: req=%b addr=%h wr=%b wstrb=%h, required 1 208 0 0",
               data_sram_req, data_sram_addr, data_sram_wr, data_sram_wstrb);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (data_sram_req !== 1'b0 || es_allowin !== 1'b0 || es_to_ds_bus !== 6'h29 ||
          es_to_ms_valid !== 1'b1 || es_forward_data !== 32'h208) begin
        errors++;
        $display("FAIL bp_hold%0d: req=%b allowin=%b ds_bus=%h ms_v=%b fwd=%h, required 0 0 29 1 208",
                 c, data_sram_req, es_allowin, es_to_ds_bus, es_to_ms_valid, es_forward_data);
      end
      tick();
    end
    ms_allowin = 1'b1;
    #1;
    checks++;
    if (es_allowin !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: allowin=%b, required 1", es_allowin);
    end
    tick();
    data_sram_addr_ok = 1'b0;
    checks++;
    if (es_valid !== 1'b0 || accept_cnt - base !== 1) begin
      errors++;
      $display("FAIL bp_done: es_valid=%b accepts=%0d, required 0 1", es_valid, accept_cnt - base);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    ms_allowin        = 1'b1;
    data_sram_addr_ok = 1'b1;
    base = accept_cnt;
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = make_bus(32'h1C000500, OP_ADD, 0, 0, 1, 1, 0, 5'd10, 32'd0, 32'h300, 32'h0, 1);
    tick();
    ds_to_es_bus   = make_bus(32'h1C000504, OP_ADD, 0, 0, 1, 1, 0, 5'd11, 32'd4, 32'h300, 32'h0, 1);
    #1;
    checks++;
    if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h300 || es_allowin !== 1'b1 ||
        es_to_ms_bus[70:39] !== 32'h1C000500) begin
      errors++;
      $display("FAIL b2b_ld1: req=%b addr=%h allowin=%b pc=%h, required 1 300 1 1c000500",
               data_sram_req, data_sram_addr, es_allowin, es_to_ms_bus[70:39]);
    end
    tick();
    ds_to_es_bus   = make_bus(32'h1C000508, OP_OR, 0, 0, 0, 1, 0, 5'd12, 32'd0, 32'h0F, 32'hF0, 0);
    #1;
    checks++;
    if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h304 || es_allowin !== 1'b1 ||
        es_to_ms_bus[70:39] !== 32'h1C000504) begin
      errors++;
      $display("FAIL b2b_ld2: req=%b addr=%h allowin=%b pc=%h, required 1 304 1 1c000504",
               data_sram_req, data_sram_addr, es_allowin, es_to_ms_bus[70:39]);
    end
    tick();
    ds_to_es_valid = 1'b0;
    #1;
    checks++;
    if (data_sram_req !== 1'b0 || es_to_ms_valid !== 1'b1 || es_forward_data !== 32'hFF ||
        es_to_ms_bus[70:39] !== 32'h1C000508) begin
      errors++;
      $display("FAIL b2b_alu: req=%b ms_v=%b fwd=%h pc=%h, required 0 1 ff 1c000508",
               data_sram_req, es_to_ms_valid, es_forward_data, es_to_ms_bus[70:39]);
    end
    tick();
    data_sram_addr_ok = 1'b0;
    checks++;
    if (accept_cnt - base !== 2 || es_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: accepts=%0d es_valid=%b, required 2 0", accept_cnt - base, es_valid);
    end
  endtask

  task automatic test_reset_mid_req();
    int base;
    ms_allowin        = 1'b1;
    data_sram_addr_ok = 1'b0;
    base = accept_cnt;
    issue(make_bus(32'h1C000600, OP_ADD, 0, 0, 1, 1, 0, 5'd4, 32'd0, 32'h400, 32'h0, 1));
    checks++;
    if (data_sram_req !== 1'b1 || es_to_ds_dest !== 5'd4) begin
      errors++;
      $display("FAIL rst_pre: req=%b dest=%0d, required 1 4", data_sram_req, es_to_ds_dest);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (data_sram_req !== 1'b0 || es_valid !== 1'b0 || es_to_ms_valid !== 1'b0 ||
        es_to_ds_dest !== 5'd0) begin
      errors++;
      $display("FAIL rst_async: req=%b es_valid=%b ms_v=%b dest=%0d, required 0 0 0 0",
               data_sram_req, es_valid, es_to_ms_valid, es_to_ds_dest);
    end
    data_sram_addr_ok = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    data_sram_addr_ok = 1'b0;
    checks++;
    if (data_sram_req !== 1'b0 || es_valid !== 1'b0 || accept_cnt - base !== 0) begin
      errors++;
      $display("FAIL rst_after: req=%b es_valid=%b accepts=%0d, required 0 0 0",
               data_sram_req, es_valid, accept_cnt - base);
    end
  endtask

  initial begin
    reset             = 1'b1;
    ms_allowin        = 1'b1;
    ds_to_es_valid    = 1'b0;
    ds_to_es_bus      = '0;
    data_sram_addr_ok = 1'b0;
    test_reset();
    test_handshake();
    test_alu();
    test_store();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage scalar pipeline, directly downstream of the decode stage.
- Latches the 151-bit decode-to-execute bus and computes the ALU result.
- Issues load/store requests to the data SRAM through a req/addr_ok handshake.
- Feeds the memory stage; returns hazard and forwarding information to decode.

Parameters:
- none

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ms_allowin  in  1  memory stage can accept an instruction.
- ds_to_es_valid  in  1  decode offers a valid instruction.
- ds_to_es_bus  in  151  {pc[150:119], alu_op[118:107], src2_is_4[106], src1_is_pc[105], src2_is_imm[104], gr_we[103], mem_we[102], dest[101:97], imm[96:65], rj_value[64:33], rkd_value[32:1], res_from_mem[0]}.
- es_allowin  out  1  execute can accept from decode.
- es_to_ms_valid  out  1  valid instruction offered to memory stage.
- es_to_ms_bus  out  71  {pc[70:39], res_from_mem[38], gr_we[37], dest[36:32], alu_result[31:0]}.
- es_valid  out  1  execute holds a valid instruction.
- es_to_ds_bus  out  6  {es_valid & res_from_mem, es_to_ds_dest}; used by decode for load-use stall.
- es_to_ds_dest  out  5  dest if es_valid & gr_we, else 0.
- es_forward_data  out  32  alu_result, forwarded to decode.
- data_sram_req  out  1  request valid.
- data_sram_wr  out  1  1 = store, 0 = load.
- data_sram_size  out  2  constant 2'b10 (word).
- data_sram_wstrb  out  4  4'hf for store, 4'h0 for load.
- data_sram_addr  out  32  alu_result.
- data_sram_wdata  out  32  rkd_value of the latched instruction.
- data_sram_addr_ok  in  1  SRAM accepts the request this cycle.

Behaviour:
- Reset (asynchronous, immediate):
  - es_valid=0, req_done=0, latched bus=0.
  - All outputs are therefore 0, except data_sram_size=2'b10.
- Latch:
  - es_valid <= ds_to_es_valid whenever es_allowin=1.
  - Bus fields are registered only when ds_to_es_valid & es_allowin.
  - Decode-to-execute latency: 1 cycle.
- Handshake:
  - es_allowin = !es_valid | (es_ready_go & ms_allowin).
  - es_to_ms_valid = es_valid & es_ready_go.
- ALU operand selection:
  - src1 = src1_is_pc ? pc : rj_value.
  - src2 = (src2_is_imm | src2_is_4) ? imm : rkd_value.
- ALU operations, alu_op one-hot; all-zero alu_op gives result 0:
  - bit 0: add.
  - bit 1: sub.
  - bit 2: slt, signed, result {31'b0, lt}.
  - bit 3: sltu, unsigned.
  - bit 4: and.
  - bit 5: nor.
  - bit 6: or.
  - bit 7: xor.
  - bit 8: sll, by src2[4:0].
  - bit 9: srl, logical.
  - bit 10: sra, arithmetic.
  - bit 11: lu12i, result = src2.
  - All arithmetic is 32-bit wrap-around; no overflow trap.
- Memory request sequencing: mem_op = res_from_mem | mem_we.
  - Per-instruction flag req_done:
    - Set on data_sram_req & data_sram_addr_ok.
    - Cleared when the instruction leaves (es_to_ms_valid & ms_allowin) or a new instruction is latched.
  - data_sram_req = es_valid & mem_op & !req_done.
  - Once asserted, req and addr/wdata/wr/wstrb are held stable until addr_ok.
  - es_ready_go = !mem_op | req_done | (data_sram_req & data_sram_addr_ok).
  - Exactly one request is issued per memory instruction, even if ms_allowin stays low for many cycles after addr_ok.
- Boundary conditions:
  - addr_ok and ms_allowin in the same cycle: the instruction advances that cycle, and req_done does not carry over to the next instruction.
  - ms_allowin=0: the bus and all forwarding outputs hold.
  - Non-memory instructions always have es_ready_go=1.
  - gr_we=0 forces es_to_ds_dest=0, so decode never matches it.
  - An invalid slot drives es_to_ds_dest=0 and es_to_ds_bus[5]=0.
- Reset during a pending request: req drops immediately with es_valid; any addr_ok arriving later is ignored.

Test Plan:
- Pipeline handshake:
  - Stimulus: add.w rj=5, rk=7, ms_allowin=1.
  - Required: one cycle later es_to_ms_valid=1, alu_result=12, es_to_ds_dest=rd, es_forward_data=12.
- ALU corners:
  - slt 0xFFFFFFFF vs 1 gives 1; sltu gives 0.
  - sra 0x80000000 by 4 gives 0xF8000000.
  - lu12i with imm 0x12345000 gives 0x12345000.
  - bl with pc=0x1C000000 gives 0x1C000004.
- Store handshake:
  - Stimulus: st.w addr=0x100, addr_ok held low 3 cycles.
  - Required: req stays high with a stable addr, wstrb=f, wr=1, and es_to_ms_valid=0; once addr_ok=1 for one cycle, exactly one accept occurs and req deasserts.
- Backpressure after accept:
  - Stimulus: ld.w accepted while ms_allowin=0 for 4 cycles.
  - Required: no second req, es_allowin=0, es_to_ds_bus[5]=1; the instruction passes when ms_allowin=1.
- Reset mid-request:
  - Stimulus: assert reset while req=1.
  - Required: req, es_valid, es_to_ms_valid and es_to_ds_dest are 0 within the same cycle (asynchronous).
- Back-to-back traffic:
  - Stimulus: two loads, then a non-memory instruction.
  - Required: exactly two requests are issued, and the third instruction advances with no stall cycle.
